// File: rtl/home_pkg.sv
// home_pkg: snapshot field layout, frame length, FSM states and snapshot packing shared by the status link.
package home_pkg;
  localparam int SNAP_BITS = 16;
  localparam int FRAME_BITS = 19;
  localparam int ALARM_MSB = 15;
  localparam int ALARM_LSB = 13;
  localparam int LIGHTS_BIT = 12;
  localparam int HEAT_BIT = 11;
  localparam int COOL_BIT = 10;
  localparam int SPRINK_BIT = 9;
  localparam int PUMP_BIT = 8;
  localparam int OCC_MSB = 7;
  localparam int OCC_LSB = 0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic [SNAP_BITS-1:0] pack_snapshot(
    input logic [2:0] alarms,
    input logic lights_on, heat_on, cool_on, sprink_on, pump_on,
    input logic [7:0] occupants
  );
    logic [SNAP_BITS-1:0] s;
    s = '0;
    s[ALARM_MSB:ALARM_LSB] = alarms;
    s[LIGHTS_BIT] = lights_on;
    s[HEAT_BIT] = heat_on;
    s[COOL_BIT] = cool_on;
    s[SPRINK_BIT] = sprink_on;
    s[PUMP_BIT] = pump_on;
    s[OCC_MSB:OCC_LSB] = occupants;
    return s;
  endfunction
endpackage

// File: rtl/home_status_tx_if.sv
// home_status_tx_if: controller status inputs and serial link outputs of the status transmitter.
//   master: drives alarms, occupants_in, actuator flags, force_send; reads tx_out, busy, frame_sent
//   slave : the transmitter side (opposite directions)
interface home_status_tx_if;
  logic [2:0] alarms;
  logic [7:0] occupants_in;
  logic lights_on;
  logic heat_on;
  logic cool_on;
  logic sprink_on;
  logic pump_on;
  logic force_send;
  logic tx_out;
  logic busy;
  logic frame_sent;
  modport master (
    output alarms, occupants_in, lights_on, heat_on, cool_on, sprink_on, pump_on, force_send,
    input tx_out, busy, frame_sent
  );
  modport slave (
    input alarms, occupants_in, lights_on, heat_on, cool_on, sprink_on, pump_on, force_send,
    output tx_out, busy, frame_sent
  );
endinterface

// File: rtl/home_baud_gen.sv
// home_baud_gen: free-running bit-time divider, restartable, one-cycle bit_tick every CLKS_PER_BIT cycles.
//   clk, reset (async, active-high), restart: zero the divider, bit_tick: last cycle of each bit time
module home_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign bit_tick = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (restart || bit_tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/home_status_tx.sv
// home_status_tx: serial snapshot transmitter (start, 16 data LSB first, even parity, stop) on change/heartbeat/request.
//   clk, reset (async, active-high)
//   bus (slave): alarms, occupants_in, actuator flags, force_send in; tx_out, busy, frame_sent out
module home_status_tx
  import home_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int HEARTBEAT_CYCLES = 4096
) (
  input logic clk,
  input logic reset,
  home_status_tx_if.slave bus
);
  localparam int HW = $clog2(HEARTBEAT_CYCLES);
  state_t state, state_nx;
  logic [SNAP_BITS-1:0] snap, shreg, last_sent;
  logic [HW-1:0] hb_cnt;
  logic [3:0] bit_cnt;
  logic parity, pending, launch, bit_tick, hb_exp, changed;
  assign snap = pack_snapshot(bus.alarms, bus.lights_on, bus.heat_on, bus.cool_on,
                              bus.sprink_on, bus.pump_on, bus.occupants_in);
  assign hb_exp = hb_cnt == HW'(HEARTBEAT_CYCLES - 1);
  assign changed = snap != last_sent;
  home_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .restart(launch),
    .bit_tick(bit_tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    launch = 1'b0;
    case (state)
      IDLE: begin
        launch = changed || hb_exp || bus.force_send || pending;
        state_nx = launch ? START : IDLE;
      end
      START:  state_nx = bit_tick ? DATA : START;
      DATA:   state_nx = (bit_tick && bit_cnt == 4'(SNAP_BITS - 1)) ? PARITY : DATA;
      PARITY: state_nx = bit_tick ? STOP : PARITY;
      STOP:   state_nx = bit_tick ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  // Events during a frame only arm one follow-up frame; the latched frame itself is frozen.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shreg <= '0;
      last_sent <= '0;
      parity <= 1'b0;
      pending <= 1'b0;
      hb_cnt <= '0;
      bit_cnt <= '0;
    end else if (launch) begin
      shreg <= snap;
      last_sent <= snap;
      parity <= ^snap;
      pending <= 1'b0;
      hb_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE && !hb_exp) hb_cnt <= hb_cnt + HW'(1);
      if (state != IDLE && (changed || bus.force_send || hb_exp)) pending <= 1'b1;
      if (state == DATA && bit_tick) begin
        shreg <= shreg >> 1;
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  assign bus.tx_out = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? parity : 1'b1;
  assign bus.busy = state != IDLE;
  assign bus.frame_sent = state == STOP && bit_tick;
endmodule

// File: tb/tb_home_status_tx.sv
// tb_home_status_tx: randomized and directed stimulus, queue scoreboard fed by a frame-level reference model, line-decoding monitor.
module tb_home_status_tx;
  localparam int C = 4;
  localparam int HB = 64;
  localparam int FL = 19 * C;
  typedef struct {
    logic [15:0] data;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  home_status_tx_if bus();
  home_status_tx #(.CLKS_PER_BIT(C), .HEARTBEAT_CYCLES(HB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  function automatic logic [15:0] snap_now();
    return {bus.alarms, bus.lights_on, bus.heat_on, bus.cool_on, bus.sprink_on, bus.pump_on, bus.occupants_in};
  endfunction
  task automatic set_snap(input logic [15:0] s);
    {bus.alarms, bus.lights_on, bus.heat_on, bus.cool_on, bus.sprink_on, bus.pump_on, bus.occupants_in} = s;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_busy(input logic lvl, input int max, input string name);
    int n;
    n = 0;
    while (bus.busy !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.busy), 32'(lvl));
  endtask
  initial begin : model
    int left, hb;
    logic [15:0] last, s;
    logic pend;
    left = 0; hb = 0; last = '0; pend = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      s = snap_now();
      if (reset) begin
        left = 0; hb = 0; last = '0; pend = 1'b0;
        q.delete();
      end else if (left > 0) begin
        left--;
        if (s != last || bus.force_send) pend = 1'b1;
      end else if (s != last || hb == HB - 1 || bus.force_send || pend) begin
        q.push_back('{s, cyc});
        last = s; pend = 1'b0; hb = 0; left = FL;
      end else hb++;
    end
  end
  initial begin : monitor
    logic smp[FL];
    logic [15:0] rx;
    logic have_e, fs_bad, busy_bad, hold_bad;
    int pos;
    exp_t e;
    pos = 0; have_e = 1'b0; fs_bad = 1'b0; busy_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) pos = 0;
      else begin
        if (pos == 0 && bus.busy) begin
          fs_bad = 1'b0; busy_bad = 1'b0;
          have_e = q.size() != 0;
          if (have_e) begin
            e = q.pop_front();
            chk("launch_cycle", cyc, e.cyc);
          end else begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got frame at cycle %0d expected none", cyc);
          end
        end
        if (pos > 0 || bus.busy) begin
          smp[pos] = bus.tx_out;
          if (bus.frame_sent !== (pos == FL - 1)) fs_bad = 1'b1;
          if (bus.busy !== 1'b1) busy_bad = 1'b1;
          pos++;
          if (pos == FL) begin
            pos = 0;
            hold_bad = 1'b0;
            for (int i = 0; i < FL; i++) if (smp[i] !== smp[(i / C) * C]) hold_bad = 1'b1;
            for (int i = 0; i < 16; i++) rx[i] = smp[(1 + i) * C];
            chk("bit_hold", 32'(hold_bad), 0);
            chk("frame_sent_pulse", 32'(fs_bad), 0);
            chk("busy_span", 32'(busy_bad), 0);
            chk("start_bit", 32'(smp[0]), 0);
            chk("stop_bit", 32'(smp[18 * C]), 1);
            chk("rx_parity_ok", 32'(^rx ^ smp[17 * C]), 0);
            if (have_e) begin
              chk("data", 32'(rx), 32'(e.data));
              chk("parity", 32'(smp[17 * C]), 32'(^e.data));
            end
          end
        end else chk("idle_line", {30'd0, bus.tx_out, bus.frame_sent}, 32'b10);
      end
    end
  end
  initial begin : stim
    int n;
    set_snap('0);
    bus.force_send = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_tx_out", 32'(bus.tx_out), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_frame_sent", 32'(bus.frame_sent), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hb_first_launch", n, 64);
    wait_busy(0, 2 * FL, "t2_idle");
    set_snap(16'h9005);
    @(negedge clk);
    chk("t2_launch", 32'(bus.busy), 1);
    repeat (10) @(negedge clk);
    bus.occupants_in = 8'd7;
    repeat (40) @(negedge clk);
    bus.occupants_in = 8'd8;
    wait_busy(0, 2 * FL, "t3_end");
    wait_busy(1, 10, "t3_follow");
    wait_busy(0, 2 * FL, "t3_follow_end");
    repeat (63) @(negedge clk);
    bus.force_send = 1'b1;
    @(negedge clk);
    bus.force_send = 1'b0;
    chk("t4_launch", 32'(bus.busy), 1);
    wait_busy(0, 2 * FL, "t4_end");
    wait_busy(1, 2 * HB, "t4_next_hb");
    wait_busy(0, 2 * FL, "t5_idle");
    set_snap(16'h5a3c);
    wait_busy(1, 10, "t5_launch");
    repeat (33) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_tx_out", 32'(bus.tx_out), 1);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_relaunch", 32'(bus.busy), 1);
    wait_busy(0, 2 * FL, "t5_end");
    set_snap(16'h0001);
    wait_busy(1, 10, "t6_launch");
    wait_busy(0, 2 * FL, "t6_end");
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 120)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: bus.occupants_in = 8'($urandom);
        1: begin
          bus.force_send = 1'b1;
          @(negedge clk);
          bus.force_send = 1'b0;
        end
        2: begin
          set_snap(16'($urandom));
          @(negedge clk);
          set_snap(16'h0001);
        end
        default: set_snap(16'($urandom));
      endcase
    end
    repeat (10) @(negedge clk);
    wait_busy(0, 2 * FL, "final_idle");
    #1;
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/home_status_tx.md
Name: home_status_tx

Overview:
Serial status transmitter that reports the controller's outputs to a remote wall panel over a single UART-style line. It sits downstream of the master controller and watches the alarm vector, the occupancy count and the five actuator flags. It sends a framed snapshot whenever any of them changes, on a periodic heartbeat, or on request. The panel-side receiver is the other end of this link.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal values are ≥2.
- HEARTBEAT_CYCLES, 4096: idle cycles after which an unchanged snapshot is re-sent; legal values are ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- alarms  in  3  {fire, door|window, rain}
- occupants_in  in  8  current occupant count
- lights_on  in  1  actuator flag
- heat_on  in  1  actuator flag
- cool_on  in  1  actuator flag
- sprink_on  in  1  actuator flag
- pump_on  in  1  actuator flag
- force_send  in  1  one-cycle request to send the current snapshot
- tx_out  out  1  serial line; idles high
- busy  out  1  high from start bit through stop bit
- frame_sent  out  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (async): tx_out=1, busy=0, frame_sent=0. State=IDLE, last_sent=16'h0000, pending=0, and the heartbeat and baud counters clear. Reset mid-frame aborts the frame and tx_out returns to 1 immediately.
- Snapshot (16 bits), from MSB to LSB: [15:13]=alarms, [12]=lights_on, [11]=heat_on, [10]=cool_on, [9]=sprink_on, [8]=pump_on, [7:0]=occupants_in.
- Frame is 19 bits:
  - start bit 0;
  - 16 data bits, LSB first;
  - even parity bit, equal to the XOR of the 16 data bits;
  - stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles, so a frame lasts 19*CLKS_PER_BIT cycles.
- Trigger = (snapshot != last_sent) OR heartbeat expiry OR force_send OR pending.
  - Heartbeat expiry occurs when the heartbeat counter reaches HEARTBEAT_CYCLES-1.
- States and transitions:
  - IDLE: if trigger is true at edge N, latch the snapshot into the shift register and into last_sent, clear pending, and clear the heartbeat counter. At edge N+1, tx_out=0 and busy=1, and the state is START.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA: shift right on each baud tick; 4-bit counter 0..15. → PARITY after bit 15.
  - PARITY → STOP after one bit time.
  - STOP: frame_sent=1 on its final cycle. → IDLE; busy=0 on the following cycle.
- While busy:
  - A snapshot change, force_send, or heartbeat expiry sets pending=1.
  - Multiple events collapse into one pending frame.
  - The latched frame is never altered.
- After STOP, IDLE lasts at least 1 cycle, then a pending frame starts. That frame carries the snapshot present at its own launch edge.
- Simultaneous triggers in one cycle produce exactly one frame.
- If inputs return to last_sent before launch, no change-trigger fires. A pending flag still forces a send.
- Heartbeat counter:
  - counts only in IDLE, saturating at HEARTBEAT_CYCLES-1;
  - is cleared at every frame launch.
- After reset with any nonzero input, the first frame launches at the first clk edge after reset deasserts.
- Counter widths: $clog2 of each parameter; no wrap is possible in legal use.

Decomposition:
- Package home_pkg holds:
  - snapshot field offsets (ALARM_MSB=15, OCC_LSB=0, etc.);
  - FRAME_BITS=19;
  - state enum {IDLE, START, DATA, PARITY, STOP}.
- Sub-module home_baud_gen:
  - free-running divider, restarted at frame launch;
  - emits a one-cycle bit_tick every CLKS_PER_BIT cycles;
  - shared with the future panel receiver.

Test Plan (CLKS_PER_BIT=4, HEARTBEAT_CYCLES=64):
1. Reset with all inputs 0, then hold them static → tx_out stays 1 and busy stays 0 for 63 idle cycles. The heartbeat frame (payload 16'h0000, parity 0) then starts at cycle 64.
2. Set alarms=3'b100, lights_on=1, occupants_in=8'd5 (snapshot 16'h9005) → the line shows:
   - start bit 0;
   - data bits LSB first 1,0,1,0,0,0,0,0,0,0,0,0,1,0,0,1;
   - parity 0, stop 1;
   - each bit held 4 cycles, 76 cycles total; frame_sent pulses once on cycle 76.
3. Set occupants_in=8'd7 while a frame is in flight, then set it to 8'd8 before the stop bit →
   - the current frame is unchanged;
   - exactly one further frame, carrying occupants=8, starts after ≥1 idle cycle.
4. Pulse force_send with an unchanged snapshot, in the same cycle as a heartbeat expiry → exactly one frame; the heartbeat counter restarts from 0.
5. Assert reset during DATA bit 7 → tx_out=1 and busy=0 asynchronously. After release, the nonzero snapshot is re-sent from its start bit.
6. Apply snapshot 16'h0001 (odd ones count) → parity bit 1, and the receiver model reports no error.
